// File: rtl/wave_voice_sched_if.sv
// Host-side bus for wave_voice_sched: sample strobe, voice config writes,
// shared sine lookup port and the mixed-sample output.
interface wave_voice_sched_if #(
   parameter int PHASE_W = 16
);
   logic                sample_en;
   logic                cfg_we;
   logic [3:0]          cfg_voice;
   logic [PHASE_W-1:0]  cfg_freq;
   logic [3:0]          cfg_vol;
   logic                cfg_en;
   logic                cfg_prst;
   logic [5:0]          lut_ramp;
   logic signed [15:0]  lut_data;
   logic signed [15:0]  mix_o;
   logic                mix_valid;
   logic                busy;
   logic                overrun;

   modport master (
      output sample_en, cfg_we, cfg_voice, cfg_freq, cfg_vol, cfg_en, cfg_prst, lut_data,
      input  lut_ramp, mix_o, mix_valid, busy, overrun
   );

   modport slave (
      input  sample_en, cfg_we, cfg_voice, cfg_freq, cfg_vol, cfg_en, cfg_prst, lut_data,
      output lut_ramp, mix_o, mix_valid, busy, overrun
   );
endinterface

// File: rtl/wave_voice_sched.sv
// Tone-voice mixer: scans VOICES phase accumulators through one shared sine
// lookup per sample strobe, scales by volume and emits a saturated sum.
module wave_voice_sched #(
   parameter int VOICES  = 4,
   parameter int PHASE_W = 16
) (
   input logic                clk,
   input logic                reset,
   wave_voice_sched_if.slave  bus
);
   localparam int VW = (VOICES > 1) ? $clog2(VOICES) : 1;

   typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

   state_t                          state_q, state_d;
   logic [VW-1:0]                   v_q, v_d;
   logic [VOICES-1:0][PHASE_W-1:0]  phase_q, phase_d;
   logic [VOICES-1:0][PHASE_W-1:0]  freq_q, freq_d;
   logic [VOICES-1:0][3:0]          vol_q, vol_d;
   logic [VOICES-1:0]               en_q, en_d;
   logic signed [23:0]              acc_q, acc_d;
   logic signed [15:0]              mix_q, mix_d;
   logic                            mix_valid_q, mix_valid_d;
   logic                            busy_q, busy_d;
   logic [5:0]                      ramp_q, ramp_d;

   logic signed [20:0]              ld_ext, vol_ext, prod;
   logic signed [23:0]              term;

   function automatic logic signed [15:0] sat16(input logic signed [23:0] a);
      if (a > 24'sd32767)       return 16'sh7fff;
      else if (a < -24'sd32768) return 16'sh8000;
      else                      return a[15:0];
   endfunction

   always_comb begin
      ld_ext  = {{5{bus.lut_data[15]}}, bus.lut_data};
      vol_ext = {17'd0, vol_q[v_q]};
      prod    = ld_ext * vol_ext;
      // floor(prod / 16), sign-extended to accumulator width
      term    = {{7{prod[20]}}, prod[20:4]};

      state_d     = state_q;
      v_d         = v_q;
      acc_d       = acc_q;
      mix_d       = mix_q;
      mix_valid_d = 1'b0;
      phase_d     = phase_q;
      freq_d      = freq_q;
      vol_d       = vol_q;
      en_d        = en_q;

      case (state_q)
         IDLE: begin
            if (bus.sample_en) begin
               state_d = SCAN;
               v_d     = '0;
               acc_d   = '0;
            end
         end
         SCAN: begin
            if (en_q[v_q]) begin
               acc_d       = acc_q + term;
               phase_d[v_q] = phase_q[v_q] + freq_q[v_q];
            end
            if (v_q == VW'(VOICES - 1)) begin
               state_d     = DONE;
               mix_d       = sat16(acc_d);
               mix_valid_d = 1'b1;
            end else begin
               v_d = v_q + 1'b1;
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase

      // Config lands after the scan update so a same-cycle prst wins over the advance.
      for (int i = 0; i < VOICES; i++) begin
         if (bus.cfg_we && bus.cfg_voice == 4'(i)) begin
            freq_d[i] = bus.cfg_freq;
            vol_d[i]  = bus.cfg_vol;
            en_d[i]   = bus.cfg_en;
            if (bus.cfg_prst) phase_d[i] = '0;
         end
      end

      busy_d = (state_d != IDLE);
      ramp_d = (state_d == SCAN) ? phase_d[v_d][PHASE_W-1 -: 6] : 6'd0;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= IDLE;
         v_q         <= '0;
         phase_q     <= '0;
         freq_q      <= '0;
         vol_q       <= '0;
         en_q        <= '0;
         acc_q       <= '0;
         mix_q       <= '0;
         mix_valid_q <= 1'b0;
         busy_q      <= 1'b0;
         ramp_q      <= '0;
      end else begin
         state_q     <= state_d;
         v_q         <= v_d;
         phase_q     <= phase_d;
         freq_q      <= freq_d;
         vol_q       <= vol_d;
         en_q        <= en_d;
         acc_q       <= acc_d;
         mix_q       <= mix_d;
         mix_valid_q <= mix_valid_d;
         busy_q      <= busy_d;
         ramp_q      <= ramp_d;
      end
   end

   assign bus.lut_ramp  = ramp_q;
   assign bus.mix_o     = mix_q;
   assign bus.mix_valid = mix_valid_q;
   assign bus.busy      = busy_q;
   // overrun must flag the offending strobe in its own cycle, so it stays combinational
   assign bus.overrun   = bus.sample_en & busy_q;
endmodule
